// File: rtl/three_logic.sv
// three_logic: f = m(0,1,2,5,8,9,10) over {A,B,C,D}, with a registered copy and a saturating count of high cycles
module three_logic #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  output logic             f,
  output logic             f_q,
  output logic [CNT_W-1:0] ones_cnt
);
  assign f = (~B & ~D) | (~B & ~C) | (~A & ~C & D);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q      <= 1'b0;
      ones_cnt <= '0;
    end else begin
      f_q <= f;
      if (f && !(&ones_cnt)) ones_cnt <= ones_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_three_logic.sv
// tb_three_logic: randomized and directed checks of three_logic against a minterm-list reference model
module tb_three_logic;
  logic clk = 0, rst = 1, A = 0, B = 0, C = 0, D = 0;
  logic f, f_q, f2, f_q2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  int errors = 0, checks = 0;
  int m_q = 0, m_c8 = 0, m_c2 = 0;

  three_logic #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
                                .f(f), .f_q(f_q), .ones_cnt(cnt8));
  three_logic #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
                                 .f(f2), .f_q(f_q2), .ones_cnt(cnt2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mf(input logic [3:0] v);
    int mins[7] = '{0, 1, 2, 5, 8, 9, 10};
    foreach (mins[i]) if (int'(v) == mins[i]) return 1;
    return 0;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_fq"}, int'(f_q), m_q);
    chk({tag, "_cnt8"}, int'(cnt8), m_c8);
    chk({tag, "_fq2"}, int'(f_q2), m_q);
    chk({tag, "_cnt2"}, int'(cnt2), m_c2);
  endtask

  task automatic step(input logic [3:0] v, input logic r);
    @(negedge clk);
    {A, B, C, D} = v;
    rst = r;
    #1;
    if (r) begin m_q = 0; m_c8 = 0; m_c2 = 0; end
    chk("f", int'(f), mf(v));
    chk("f2", int'(f2), mf(v));
    if (r) check_regs("rst_now");
    @(posedge clk);
    if (!r) begin
      m_q = mf(v);
      if (m_q == 1) begin
        m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
        m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
      end
    end
    #1;
    check_regs("edge");
  endtask

  initial begin
    int sat_exp[6] = '{1, 2, 3, 3, 3, 3};
    logic [3:0] zeros[9] = '{4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1011,
                             4'b1100, 4'b1101, 4'b1110, 4'b1111};
    for (int i = 0; i < 16; i++) begin
      {A, B, C, D} = 4'(i);
      #1;
      chk("sweep_f", int'(f), mf(4'(i)));
      chk("sweep_fq", int'(f_q), 0);
      chk("sweep_cnt", int'(cnt8), 0);
      #19;
    end
    for (int i = 0; i < 3; i++) step(4'b0101, 1'b0);
    chk("held_fq", int'(f_q), 1);
    chk("held_cnt", int'(cnt8), 3);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    chk("pre_async_cnt", int'(cnt8), 5);
    @(negedge clk);
    {A, B, C, D} = 4'b0000;
    #2 rst = 1;
    #1;
    m_q = 0; m_c8 = 0; m_c2 = 0;
    chk("async_fq", int'(f_q), 0);
    chk("async_cnt", int'(cnt8), 0);
    chk("async_f", int'(f), 1);
    for (int i = 0; i < 6; i++) begin
      step(4'b1000, 1'b0);
      chk("sat_seq", int'(cnt2), sat_exp[i]);
    end
    foreach (zeros[i]) begin
      step(zeros[i], 1'b0);
      chk("zero_f", int'(f), 0);
    end
    chk("zero_cnt", int'(cnt8), 6);
    for (int i = 0; i < 1200; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 199) == 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
